// File: rtl/eeprom_writer.sv
// eeprom_writer: SPI mode-0 master that programs a 25xx EEPROM (WREN, WRITE, RDSR poll)
// and splits a byte stream into page-bounded write transactions.
module eeprom_writer #(
    parameter int PAGE_SIZE  = 16,
    parameter int POLL_LIMIT = 1023,
    parameter int CS_GAP     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        sck,
    output logic        copi,
    input  logic        cipo,
    output logic        cs_n
);
    localparam int PW = $clog2(PAGE_SIZE);
    localparam int GW = $clog2(CS_GAP + 1);

    typedef enum logic [3:0] {IDLE, WREN, GAP, WCMD, ADDR, LOAD, DATA, PCMD, PREAD, DONE, ERR} state_t;

    state_t        state_q, state_d, nxt_q, nxt_d;
    logic [15:0]   addr_q, addr_d, addr_inc;
    logic [7:0]    sh_q, sh_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [9:0]    pcnt_q, pcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          last_q, last_d, hi_q, hi_d, err_q, err_d;
    logic          shifting, byte_end;

    assign addr_inc = addr_q + 16'd1;
    assign shifting = state_q inside {WREN, WCMD, ADDR, DATA, PCMD, PREAD};
    assign byte_end = bcnt_q == 4'd15;
    // Outputs decode registered state so an async reset deselects the part at once
    assign cs_n     = !(shifting || state_q == LOAD);
    assign sck      = shifting && bcnt_q[0];
    assign copi     = shifting && state_q != PREAD && sh_q[7];
    assign wr_ready = state_q == LOAD;
    assign busy     = !(state_q inside {IDLE, DONE, ERR});
    assign done     = state_q == DONE;
    assign error    = err_q;

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        bcnt_d  = shifting ? bcnt_q + 4'd1 : 4'd0;
        gcnt_d  = state_q == GAP ? gcnt_q + 1'b1 : '0;
        pcnt_d  = pcnt_q;
        last_d  = last_q;
        hi_d    = hi_q;
        err_d   = err_q;
        if (shifting && bcnt_q[0])
            sh_d = {sh_q[6:0], cipo};
        case (state_q)
            IDLE: if (start) begin
                state_d = WREN;
                addr_d  = start_addr;
                err_d   = 1'b0;
                sh_d    = 8'h06;
            end
            WREN: if (byte_end) begin
                state_d = GAP;
                nxt_d   = WCMD;
            end
            GAP: if (gcnt_q == GW'(CS_GAP - 1)) begin
                state_d = nxt_q;
                sh_d    = nxt_q == WCMD ? 8'h02 : nxt_q == PCMD ? 8'h05 : 8'h06;
                pcnt_d  = '0;
            end
            WCMD: if (byte_end) begin
                state_d = ADDR;
                sh_d    = addr_q[15:8];
                hi_d    = 1'b1;
            end
            ADDR: if (byte_end) begin
                sh_d = addr_q[7:0];
                hi_d = 1'b0;
                if (!hi_q)
                    state_d = LOAD;
            end
            LOAD: if (wr_valid) begin
                state_d = DATA;
                sh_d    = wr_data;
                last_d  = wr_last;
            end
            // A page boundary (including 0xFFFF->0x0000) always closes the write
            DATA: if (byte_end) begin
                addr_d = addr_inc;
                if (last_q || addr_inc[PW-1:0] == '0) begin
                    state_d = GAP;
                    nxt_d   = PCMD;
                end else
                    state_d = LOAD;
            end
            PCMD: if (byte_end)
                state_d = PREAD;
            PREAD: if (byte_end) begin
                pcnt_d = pcnt_q + 10'd1;
                if (!cipo) begin
                    state_d = last_q ? DONE : GAP;
                    nxt_d   = WREN;
                end else if (pcnt_q == 10'(POLL_LIMIT - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nxt_q   <= IDLE;
            addr_q  <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            pcnt_q  <= '0;
            gcnt_q  <= '0;
            last_q  <= 1'b0;
            hi_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            gcnt_q  <= gcnt_d;
            last_q  <= last_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end
endmodule
